// File: rtl/rx_decoder_pkg.sv
// Shared types and constants for the RGMII/AXI-Stream receive decoder.
package rx_decoder_pkg;

  // Decoder FSM: sink header, forward payload, or discard the rest of a frame
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_t;

  // Ethernet header lengths without and with an 802.1Q tag
  localparam int HDR_LEN_BASIC = 14;
  localparam int HDR_LEN_VLAN  = 18;

  // 802.1Q tag protocol identifier
  localparam logic [15:0] TPID_VLAN = 16'h8100;

  // Byte idx (0 = most significant) of a 48-bit MAC address
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] w_sh;
    w_sh = mac << {idx, 3'b000};
    return w_sh[47:40];
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: holds a byte until the downstream takes it.
module axis_out_reg (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last
);

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_last;

  // Load has priority so a same-cycle handshake and reload keeps the register full
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/kc705_ethernet_rgmii_axi_rx_decoder.sv
// Receive-side frame decoder: checks the MAC (and optional VLAN) header and
// forwards up to MAX_SIZE payload bytes on an AXI-Stream byte interface.
module kc705_ethernet_rgmii_axi_rx_decoder
  import rx_decoder_pkg::*;
#(
  parameter logic [47:0] DEST_ADDR     = 48'hda0102030405,
  parameter logic [47:0] SRC_ADDR      = 48'h5a0102030405,
  parameter logic [15:0] MAX_SIZE      = 16'd1500,
  parameter logic [15:0] MIN_SIZE      = 16'd64,
  parameter logic        ENABLE_VLAN   = 1'b0,
  parameter logic [11:0] VLAN_ID       = 12'd2,
  parameter logic [2:0]  VLAN_PRIORITY = 3'd2
) (
  input  logic       axi_tclk,
  input  logic       axi_tresetn,
  input  logic       enable_rx_decode,
  input  logic [1:0] speed,
  input  logic [7:0] rx_axis_tdata,
  input  logic       rx_axis_tvalid,
  input  logic       rx_axis_tlast,
  output logic       rx_axis_tready,
  output logic [7:0] tdata,
  output logic       tvalid,
  output logic       tlast,
  input  logic       tready
);

  localparam int         HDR_LEN  = ENABLE_VLAN ? HDR_LEN_VLAN : HDR_LEN_BASIC;
  localparam logic [4:0] HDR_LAST = 5'(HDR_LEN - 1);

  rx_state_t   r_state;
  rx_state_t   w_state_next;
  logic [4:0]  r_hdr_cnt;
  logic [15:0] r_pay_cnt;
  logic        r_ucast_ok;
  logic        r_bcast_ok;
  logic        r_vlan_ok;
  logic        r_rdy_en;

  logic        w_beat;
  logic        w_first;
  logic [4:0]  w_idx;
  logic        w_ucast_ok;
  logic        w_bcast_ok;
  logic        w_vlan_ok;
  logic        w_hdr_pass;
  logic [15:0] w_pay_cnt_inc;
  logic        w_max_hit;
  logic        w_load;
  logic        w_unused;

  // Link speed and the remote MAC / minimum size do not influence decoding
  assign w_unused = ^{speed, DEST_ADDR, MIN_SIZE};

  assign w_beat        = rx_axis_tvalid & rx_axis_tready;
  assign w_pay_cnt_inc = r_pay_cnt + 16'd1;
  assign w_max_hit     = (w_pay_cnt_inc == MAX_SIZE);

  // Running header checks including the byte currently on the input
  always_comb begin
    w_first    = (r_state == ST_IDLE);
    w_idx      = w_first ? 5'd0 : r_hdr_cnt;
    w_ucast_ok = w_first ? 1'b1 : r_ucast_ok;
    w_bcast_ok = w_first ? 1'b1 : r_bcast_ok;
    w_vlan_ok  = w_first ? 1'b1 : r_vlan_ok;
    if (w_idx < 5'd6) begin
      if (rx_axis_tdata != mac_byte(SRC_ADDR, w_idx[2:0])) w_ucast_ok = 1'b0;
      if (rx_axis_tdata != 8'hFF)                          w_bcast_ok = 1'b0;
    end
    if (ENABLE_VLAN) begin
      if (w_idx == 5'd12 && rx_axis_tdata != TPID_VLAN[15:8]) w_vlan_ok = 1'b0;
      if (w_idx == 5'd13 && rx_axis_tdata != TPID_VLAN[7:0])  w_vlan_ok = 1'b0;
      if (w_idx == 5'd14 && (rx_axis_tdata[7:5] != VLAN_PRIORITY ||
                             rx_axis_tdata[3:0] != VLAN_ID[11:8])) w_vlan_ok = 1'b0;
      if (w_idx == 5'd15 && rx_axis_tdata != VLAN_ID[7:0])    w_vlan_ok = 1'b0;
    end
    w_hdr_pass = (w_ucast_ok | w_bcast_ok) & w_vlan_ok;
  end

  // FSM state register
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) r_state <= ST_IDLE;
    else              r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_beat && !rx_axis_tlast)
          w_state_next = enable_rx_decode ? ST_HEADER : ST_DROP;
      end
      ST_HEADER: begin
        if (w_beat) begin
          if (rx_axis_tlast)              w_state_next = ST_IDLE;
          else if (r_hdr_cnt == HDR_LAST) w_state_next = w_hdr_pass ? ST_PAYLOAD : ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (w_beat) begin
          if (rx_axis_tlast)  w_state_next = ST_IDLE;
          else if (w_max_hit) w_state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (w_beat && rx_axis_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: full-rate sink outside PAYLOAD, register-gated inside it
  always_comb begin
    rx_axis_tready = 1'b0;
    if (r_rdy_en)
      rx_axis_tready = (r_state == ST_PAYLOAD) ? (~tvalid | tready) : 1'b1;
    w_load = w_beat && (r_state == ST_PAYLOAD);
  end

  // Header byte counter, accumulated match flags and ready enable after reset
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      r_hdr_cnt  <= 5'd0;
      r_ucast_ok <= 1'b0;
      r_bcast_ok <= 1'b0;
      r_vlan_ok  <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_beat && (r_state == ST_IDLE || r_state == ST_HEADER)) begin
        r_hdr_cnt  <= w_idx + 5'd1;
        r_ucast_ok <= w_ucast_ok;
        r_bcast_ok <= w_bcast_ok;
        r_vlan_ok  <= w_vlan_ok;
      end
    end
  end

  // Payload byte counter, restarted for every frame
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn)               r_pay_cnt <= 16'd0;
    else if (r_state != ST_PAYLOAD) r_pay_cnt <= 16'd0;
    else if (w_beat)                r_pay_cnt <= w_pay_cnt_inc;
  end

  axis_out_reg u_out_reg (
    .i_clk   (axi_tclk),
    .i_rst_n (axi_tresetn),
    .i_load  (w_load),
    .i_data  (rx_axis_tdata),
    .i_last  (rx_axis_tlast | w_max_hit),
    .i_ready (tready),
    .o_data  (tdata),
    .o_valid (tvalid),
    .o_last  (tlast)
  );

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_rx_decoder.sv
// Directed bench: three decoder instances (MAX_SIZE 500, MAX_SIZE 4, VLAN)
// share stimulus; the one under test is picked by sel.
module tb_kc705_ethernet_rgmii_axi_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] speed = 2'b10;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_last = 1'b0;
  logic       tready = 1'b1;

  logic [7:0] tdata_a, tdata_b, tdata_c;
  logic       tvalid_a, tvalid_b, tvalid_c;
  logic       tlast_a, tlast_b, tlast_c;
  logic       rdy_a, rdy_b, rdy_c;

  int         sel = 0;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_rdy;

  always #5 clk = ~clk;

  kc705_ethernet_rgmii_axi_rx_decoder #(.MAX_SIZE(16'd500)) dut_a (
    .axi_tclk(clk), .axi_tresetn(rst_n), .enable_rx_decode(en), .speed(speed),
    .rx_axis_tdata(rx_data), .rx_axis_tvalid(rx_valid), .rx_axis_tlast(rx_last),
    .rx_axis_tready(rdy_a), .tdata(tdata_a), .tvalid(tvalid_a), .tlast(tlast_a), .tready(tready));

  kc705_ethernet_rgmii_axi_rx_decoder #(.MAX_SIZE(16'd4)) dut_b (
    .axi_tclk(clk), .axi_tresetn(rst_n), .enable_rx_decode(en), .speed(speed),
    .rx_axis_tdata(rx_data), .rx_axis_tvalid(rx_valid), .rx_axis_tlast(rx_last),
    .rx_axis_tready(rdy_b), .tdata(tdata_b), .tvalid(tvalid_b), .tlast(tlast_b), .tready(tready));

  kc705_ethernet_rgmii_axi_rx_decoder #(.MAX_SIZE(16'd500), .ENABLE_VLAN(1'b1)) dut_c (
    .axi_tclk(clk), .axi_tresetn(rst_n), .enable_rx_decode(en), .speed(speed),
    .rx_axis_tdata(rx_data), .rx_axis_tvalid(rx_valid), .rx_axis_tlast(rx_last),
    .rx_axis_tready(rdy_c), .tdata(tdata_c), .tvalid(tvalid_c), .tlast(tlast_c), .tready(tready));

  always_comb begin
    m_tdata = tdata_a; m_tvalid = tvalid_a; m_tlast = tlast_a; m_rdy = rdy_a;
    if (sel == 1) begin
      m_tdata = tdata_b; m_tvalid = tvalid_b; m_tlast = tlast_b; m_rdy = rdy_b;
    end else if (sel == 2) begin
      m_tdata = tdata_c; m_tvalid = tvalid_c; m_tlast = tlast_c; m_rdy = rdy_c;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Output monitor: record handshakes and flag any change while stalled
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];
  int         out_cyc_q[$];
  int         beat_cyc_q[$];
  int         stab_err = 0;
  logic       hold_chk = 1'b0;
  logic [7:0] hold_data = 8'd0;

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (hold_chk && (!m_tvalid || m_tdata !== hold_data)) stab_err++;
      if (m_tvalid && tready) begin
        got_q.push_back({m_tlast, m_tdata});
        out_cyc_q.push_back(cyc);
      end
      hold_chk  = m_tvalid && !tready;
      hold_data = m_tdata;
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Backpressure pattern: 20 cycles open, 32 closed, then 3-on/1-off
  int bp_mode = 0;
  int bp_c = 0;
  initial forever begin
    @(negedge clk);
    if (bp_mode == 1) begin
      if (bp_c < 20)      tready = 1'b1;
      else if (bp_c < 52) tready = 1'b0;
      else                tready = ((bp_c % 4) != 3);
      bp_c++;
    end
  end

  logic [15:0] gap_pat = 16'b1011_0110_1110_0101;

  task automatic send(input bit with_last, input bit gaps, input int hdr_len,
                      input int en_off_at, output int stalls, output int full_rdy);
    int i = 0;
    int t = 0;
    int k = 0;
    stalls = 0;
    full_rdy = 0;
    while (i < tx_q.size() && t < 2000) begin
      @(negedge clk);
      if (i == en_off_at) en = 1'b0;
      rx_valid = gaps ? gap_pat[k % 16] : 1'b1;
      k++;
      rx_data = tx_q[i];
      rx_last = with_last && (i == tx_q.size() - 1);
      #1;
      if (rx_valid && !m_rdy) stalls++;
      if (i >= hdr_len && m_tvalid && !tready && m_rdy) full_rdy++;
      if (rx_valid && m_rdy) begin
        beat_cyc_q.push_back(cyc);
        i++;
      end
      t++;
    end
    if (i < tx_q.size()) check_eq("send_timeout", i, tx_q.size());
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic add_hdr(input logic [47:0] dst);
    for (int k = 0; k < 6; k++) tx_q.push_back(dst[47 - 8*k -: 8]);
    for (int k = 6; k < 12; k++) tx_q.push_back(8'(k));
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h22);
  endtask

  task automatic add_vhdr(input logic [7:0] vid_lo);
    logic [47:0] me;
    me = 48'h5a0102030405;
    for (int k = 0; k < 6; k++) tx_q.push_back(me[47 - 8*k -: 8]);
    for (int k = 6; k < 12; k++) tx_q.push_back(8'(k));
    tx_q.push_back(8'h81); tx_q.push_back(8'h00);
    tx_q.push_back(8'h40); tx_q.push_back(vid_lo);
    tx_q.push_back(8'h08); tx_q.push_back(8'h00);
  endtask

  task automatic add_bytes(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) tx_q.push_back(first + 8'(k));
  endtask

  task automatic exp_seq(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, first + 8'(k)});
  endtask

  task automatic clear_all;
    got_q.delete(); exp_q.delete(); tx_q.delete();
    out_cyc_q.delete(); beat_cyc_q.delete();
    stab_err = 0;
  endtask

  task automatic compare(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check_eq($sformatf("%s_byte%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic do_reset(input int new_sel);
    @(negedge clk);
    rst_n = 1'b0;
    sel = new_sel;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain;
    repeat (80) @(negedge clk);
  endtask

  localparam logic [47:0] ME = 48'h5a0102030405;
  localparam logic [47:0] BAD = 48'h5a0102030406;
  localparam logic [47:0] BC = 48'hffffffffffff;

  initial begin
    int st;
    int fr;

    // Reset values
    @(negedge clk); #1;
    check_eq("rst_tvalid", tvalid_a, 0);
    check_eq("rst_tdata", tdata_a, 0);
    check_eq("rst_tlast", tlast_a, 0);
    check_eq("rst_rx_tready", rdy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rx_tready_after_release", m_rdy, 1);

    // Matching frame, 1-cycle latency
    clear_all; add_hdr(ME); add_bytes(8'h0e, 33); exp_seq(8'h0e, 33);
    send(1, 0, 14, -1, st, fr); drain;
    compare("basic");
    check_eq("basic_stalls", st, 0);
    for (int k = 0; k < got_q.size() && 14 + k < beat_cyc_q.size(); k++)
      check_eq($sformatf("basic_latency%0d", k), out_cyc_q[k] - beat_cyc_q[14 + k], 1);

    // Wrong destination
    clear_all; add_hdr(BAD); add_bytes(8'h80, 12);
    send(1, 0, 14, -1, st, fr); drain;
    check_eq("wrong_dest_count", got_q.size(), 0);
    check_eq("wrong_dest_stalls", st, 0);

    // Broadcast, enable dropped mid-header must not matter
    clear_all; add_hdr(BC); add_bytes(8'h90, 3); exp_seq(8'h90, 3);
    send(1, 0, 14, 3, st, fr); drain;
    en = 1'b1;
    compare("bcast_en_mid");

    // Backpressure
    clear_all; add_hdr(ME); add_bytes(8'h0e, 33); exp_seq(8'h0e, 33);
    @(negedge clk); bp_c = 0; bp_mode = 1;
    send(1, 0, 14, -1, st, fr); drain;
    bp_mode = 0; tready = 1'b1;
    compare("bp");
    check_eq("bp_stable", stab_err, 0);
    check_eq("bp_ready_while_full", fr, 0);
    check_eq("bp_saw_stall", st > 0, 1);

    // Input gaps
    clear_all; add_hdr(ME); add_bytes(8'h0e, 33); exp_seq(8'h0e, 33);
    send(1, 1, 14, -1, st, fr); drain;
    compare("gaps");

    // Decode disabled
    clear_all; add_hdr(ME); add_bytes(8'h0e, 33);
    @(negedge clk); en = 1'b0;
    send(1, 0, 14, -1, st, fr); drain;
    en = 1'b1;
    check_eq("disabled_count", got_q.size(), 0);

    // tlast inside header discards, next frame fine
    clear_all; add_hdr(ME);
    tx_q = tx_q[0:7];
    send(1, 0, 14, -1, st, fr);
    tx_q.delete(); add_hdr(ME); add_bytes(8'h0e, 33); exp_seq(8'h0e, 33);
    send(1, 0, 14, -1, st, fr); drain;
    compare("hdr_tlast");

    // MAX_SIZE = 4: truncation, recovery, tlast exactly at limit
    do_reset(1);
    clear_all; add_hdr(ME); add_bytes(8'h40, 10);
    send(1, 0, 14, -1, st, fr);
    exp_seq(8'h40, 4);
    tx_q.delete(); add_hdr(ME); add_bytes(8'h50, 3); exp_seq(8'h50, 3);
    send(1, 0, 14, -1, st, fr);
    tx_q.delete(); add_hdr(ME); add_bytes(8'h60, 4); exp_seq(8'h60, 4);
    send(1, 0, 14, -1, st, fr);
    tx_q.delete(); add_hdr(ME); add_bytes(8'h70, 2); exp_seq(8'h70, 2);
    send(1, 0, 14, -1, st, fr); drain;
    compare("max4");

    // VLAN: good, wrong VID, good
    do_reset(2);
    clear_all; add_vhdr(8'h02); add_bytes(8'ha0, 3); exp_seq(8'ha0, 3);
    send(1, 0, 18, -1, st, fr);
    tx_q.delete(); add_vhdr(8'h03); add_bytes(8'hb0, 5);
    send(1, 0, 18, -1, st, fr);
    tx_q.delete(); add_vhdr(8'h02); add_bytes(8'hc0, 2); exp_seq(8'hc0, 2);
    send(1, 0, 18, -1, st, fr); drain;
    compare("vlan");

    // Reset mid-payload
    do_reset(0);
    clear_all; add_hdr(ME); add_bytes(8'h0e, 5);
    send(0, 0, 14, -1, st, fr);
    #1;
    check_eq("rst_mid_tvalid_before", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tvalid", m_tvalid, 0);
    check_eq("rst_mid_rx_tready", m_rdy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_all; add_hdr(ME); add_bytes(8'h0e, 33); exp_seq(8'h0e, 33);
    send(1, 0, 14, -1, st, fr); drain;
    compare("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
